// File: rtl/silly_function.sv
// silly_function: three-input Boolean function with a registered result
// path and two saturating statistics counters.
//
// y is a pure table lookup on {a,b,c}; the table is a parameter so the same
// block can stand in for any three-input function. The registered path and
// counters capture y whenever in_valid is high at a rising edge.
//
// Handshake: in_valid is a one-sided strobe with no ready. A sample is
// accepted at every rising edge where reset is high and in_valid is high.
// out_valid pulses for exactly one cycle after each accepted sample, and
// y_q carries that sample's y. There is no backpressure, so one sample per
// clock is sustained.
module silly_function #(
    parameter logic [7:0] TRUTH_TABLE = 8'h31,  // bit i is y for {a,b,c} == i
    parameter int         CNT_W       = 32      // counter width, 2..32
) (
    input  logic             clk,
    input  logic             reset,       // asynchronous, active low
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             in_valid,
    input  logic             clear,
    output logic             y,
    output logic             y_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] eval_count,
    output logic [CNT_W-1:0] ones_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0] sel;

    assign sel = {a, b, c};

    // Combinational result: a straight table lookup, independent of clock,
    // reset and the sample strobe.
    assign y = TRUTH_TABLE[sel];

    // Registered copy of y plus its one-cycle valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= y;
            end
        end
    end

    // Saturating statistics counters; clear beats a coincident sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_count <= '0;
            ones_count <= '0;
        end else if (clear) begin
            eval_count <= '0;
            ones_count <= '0;
        end else if (in_valid) begin
            if (eval_count != CNT_MAX) begin
                eval_count <= eval_count + CNT_ONE;
            end
            if (y && (ones_count != CNT_MAX)) begin
                ones_count <= ones_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_silly_function.sv
// Bench for silly_function: three instances share one stimulus stream
// (default table at full width, default table with 4-bit counters, and the
// 8'hFE table) and are compared against a behavioural model every cycle.
module tb_silly_function;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;

    logic        y0, yq0, ov0;
    logic [31:0] ec0, oc0;
    logic        y1, yq1, ov1;
    logic [3:0]  ec1, oc1;
    logic        y2, yq2, ov2;
    logic [7:0]  ec2, oc2;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    silly_function #(.TRUTH_TABLE(8'h31), .CNT_W(32)) dut_full (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .clear(clear),
        .y(y0), .y_q(yq0), .out_valid(ov0),
        .eval_count(ec0), .ones_count(oc0)
    );

    silly_function #(.TRUTH_TABLE(8'h31), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .clear(clear),
        .y(y1), .y_q(yq1), .out_valid(ov1),
        .eval_count(ec1), .ones_count(oc1)
    );

    silly_function #(.TRUTH_TABLE(8'hFE), .CNT_W(8)) dut_alt (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .clear(clear),
        .y(y2), .y_q(yq2), .out_valid(ov2),
        .eval_count(ec2), .ones_count(oc2)
    );

    // ---------------- reference model ----------------
    function automatic logic ref_default(input logic ra, input logic rb, input logic rc);
        return (~rb & ~rc) | (ra & ~rb);
    endfunction

    function automatic logic ref_alt(input logic ra, input logic rb, input logic rc);
        return ra | rb | rc;
    endfunction

    function automatic longint sat_inc(input longint v, input longint max);
        return (v >= max) ? max : v + 1;
    endfunction

    logic   m_ov = 1'b0;
    logic   m_yq0 = 1'b0;
    logic   m_yq2 = 1'b0;
    longint m_ec0 = 0, m_oc0 = 0;
    longint m_ec1 = 0, m_oc1 = 0;
    longint m_ec2 = 0, m_oc2 = 0;
    logic [0:0] exp_q[$];

    // Model of the accepting edge and of the asynchronous reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ov  <= 1'b0;
            m_yq0 <= 1'b0;
            m_yq2 <= 1'b0;
            m_ec0 <= 0; m_oc0 <= 0;
            m_ec1 <= 0; m_oc1 <= 0;
            m_ec2 <= 0; m_oc2 <= 0;
            exp_q.delete();
        end else begin
            m_ov <= in_valid;
            if (in_valid) begin
                m_yq0 <= ref_default(a, b, c);
                m_yq2 <= ref_alt(a, b, c);
                exp_q.push_back(ref_default(a, b, c));
            end
            if (clear) begin
                m_ec0 <= 0; m_oc0 <= 0;
                m_ec1 <= 0; m_oc1 <= 0;
                m_ec2 <= 0; m_oc2 <= 0;
            end else if (in_valid) begin
                m_ec0 <= sat_inc(m_ec0, 64'hFFFF_FFFF);
                m_ec1 <= sat_inc(m_ec1, 15);
                m_ec2 <= sat_inc(m_ec2, 255);
                if (ref_default(a, b, c)) begin
                    m_oc0 <= sat_inc(m_oc0, 64'hFFFF_FFFF);
                    m_oc1 <= sat_inc(m_oc1, 15);
                end
                if (ref_alt(a, b, c)) begin
                    m_oc2 <= sat_inc(m_oc2, 255);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: y_q of each out_valid pulse must match its own sample.
    task automatic check_all();
        logic [0:0] e;
        check("y_full", {31'b0, y0}, {31'b0, ref_default(a, b, c)});
        check("y_sat",  {31'b0, y1}, {31'b0, ref_default(a, b, c)});
        check("y_alt",  {31'b0, y2}, {31'b0, ref_alt(a, b, c)});
        check("ov_full", {31'b0, ov0}, {31'b0, m_ov});
        check("ov_sat",  {31'b0, ov1}, {31'b0, m_ov});
        check("ov_alt",  {31'b0, ov2}, {31'b0, m_ov});
        if (m_ov) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_yq", {31'b0, yq0}, {31'b0, e});
            end
        end
        check("yq_full", {31'b0, yq0}, {31'b0, m_yq0});
        check("yq_sat",  {31'b0, yq1}, {31'b0, m_yq0});
        check("yq_alt",  {31'b0, yq2}, {31'b0, m_yq2});
        check("eval_full", ec0, m_ec0[31:0]);
        check("ones_full", oc0, m_oc0[31:0]);
        check("eval_sat",  {28'b0, ec1}, m_ec1[31:0]);
        check("ones_sat",  {28'b0, oc1}, m_oc1[31:0]);
        check("eval_alt",  {24'b0, ec2}, m_ec2[31:0]);
        check("ones_alt",  {24'b0, oc2}, m_oc2[31:0]);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; checks at the falling edge and
    // returns just after the next rising edge.
    task automatic drive(input logic [2:0] abc, input logic v, input logic clr);
        {a, b, c} = abc;
        in_valid  = v;
        clear     = clr;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] v3;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        check("rst_eval", ec0, 0);
        check("rst_ov", {31'b0, ov0}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // exhaustive truth table through the pipeline
        for (int i = 0; i < 8; i++) begin
            v3 = i[2:0];
            drive(v3, 1'b1, 1'b0);
        end
        drive(3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check("pipe_eval", ec0, 8);
        check("pipe_ones", oc0, 3);
        @(posedge clk);
        #1;

        // clear colliding with an accepted sample
        for (int i = 0; i < 5; i++) drive(3'($urandom_range(0, 7)), 1'b1, 1'b0);
        drive(3'b000, 1'b1, 1'b1);
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        check("clr_eval", ec0, 0);
        check("clr_ones", oc0, 0);
        check("clr_yq", {31'b0, yq0}, 1);
        check("clr_ov", {31'b0, ov0}, 1);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;

        // saturation of the 4-bit instance
        for (int i = 0; i < 20; i++) drive(3'b100, 1'b1, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        check("sat_eval", {28'b0, ec1}, 15);
        check("sat_ones", {28'b0, oc1}, 15);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
        end

        // asynchronous reset between edges, mid-stream
        drive(3'b100, 1'b1, 1'b0);
        {a, b, c} = 3'b101;
        #2;
        reset = 1'b0;
        #1;
        check("arst_yq", {31'b0, yq0}, 0);
        check("arst_ov", {31'b0, ov0}, 0);
        check("arst_eval", ec0, 0);
        check("arst_ones_sat", {28'b0, oc1}, 0);
        check("arst_eval_alt", {24'b0, ec2}, 0);
        check("arst_y", {31'b0, y0}, {31'b0, ref_default(a, b, c)});
        {a, b, c} = 3'b000;
        #1;
        check("arst_y_alt", {31'b0, y2}, 0);
        check("arst_y_track", {31'b0, y0}, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
        drive(3'b000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/silly_function.md
# silly_function

Three-input Boolean function block: evaluates y = (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c), equivalently y = (~b & ~c) | (a & ~b), combinationally. It also provides a registered copy of the result with a valid flag and two saturating statistics counters. It serves as the reference combinational leaf for the team's vector-driven bench flow. Benches apply vectors shortly after the rising edge and check y before the falling edge.

## Interface
- TRUTH_TABLE, 8'h31, bit i is y for {a,b,c} == i; default gives ones at indices 0, 4, 5
- CNT_W, 32, width of both statistics counters (legal range 2..32)
- clk  input  1  single clock; all registers update on its rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all registers immediately
- a, b, c  input  1 each  function inputs
- y  output  1  combinational result, TRUTH_TABLE[{a,b,c}]
- in_valid  input  1  samples the current {a,b,c} into the registered path and counters
- clear  input  1  synchronous clear of both counters
- y_q  output  1  registered y of the last valid sample
- out_valid  output  1  high for one cycle after each accepted sample
- eval_count  output  CNT_W  number of accepted samples, saturating
- ones_count  output  CNT_W  number of accepted samples with y == 1, saturating

## Operation
- y is purely combinational from a, b, c; it is independent of clk, reset, in_valid and clear.
- For any known 0/1 inputs, y is a known 0/1 value, never X or Z.
- Default truth table ({a,b,c} -> y): 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
- Accepted sample: in_valid == 1 at a rising edge with reset high.
  - y_q <= y and out_valid <= 1.
  - Otherwise out_valid <= 0 and y_q holds its value.
- eval_count increments by 1 per accepted sample. ones_count increments by 1 per accepted sample with y == 1.
- Counters saturate at all-ones (2^CNT_W - 1) and never wrap.
- clear == 1 at an edge sets both counters to 0. If an accepted sample lands in the same cycle, clear wins and the sample is not counted; y_q/out_valid still update.
- Reset (reset == 0): y_q = 0, out_valid = 0, eval_count = 0, ones_count = 0, asynchronously.
  - Reset asserted mid-stream discards any in-flight sample.
  - Deassertion is sampled at the next rising edge. The first accepted sample is the first edge with reset high and in_valid high.

## Timing
- y: zero-cycle latency; settles within the combinational delay after input change.
- y_q, out_valid: one-cycle latency from the accepting edge.
- Counters: visible one cycle after the accepting edge.
- No backpressure; in_valid may be high every cycle (throughput 1 sample/clk).
- Back-to-back samples produce back-to-back out_valid pulses, each y_q matching its own sample.

## Test plan
- Exhaustive: apply {a,b,c} = 000..111, checking y at mid-cycle -> 1,0,0,0,1,1,0,0. Mismatch counting uses case-inequality, so X fails.
- Pipeline: reset low then high; in_valid=1 for 8 cycles with inputs 000..111 -> out_valid high 8 cycles one edge later, y_q = 1,0,0,0,1,1,0,0; eval_count=8, ones_count=3.
- Clear collision: after 5 samples assert clear together with in_valid on input 000 -> both counters 0 next cycle, y_q=1, out_valid=1.
- Saturation with CNT_W=4: 20 samples of input 100 -> eval_count and ones_count stick at 15.
- Async reset mid-stream: drop reset between edges during a run -> y_q, out_valid and counters go to 0 before the next edge. y keeps tracking inputs throughout.
- Alternate TRUTH_TABLE=8'hFE: input 000 -> y=0; any other input -> y=1.
